// File: rtl/ff_bank_write_arbiter.sv
// Round-robin write arbiter sharing one falling-edge register bank between 4 requesters.
// Each accepted request is granted for one cycle, then written if req is still held.
module ff_bank_write_arbiter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               clear,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] d_bus,
  output logic [3:0]         gnt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   qbar,
  output logic [1:0]         last_id
);

  localparam int unsigned N_REQ = 4;

  typedef enum logic {IDLE, GRANT} state_e;

  state_e             state_q, state_d;
  logic [3:0]         gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   qbar_q, qbar_d;
  logic [1:0]         last_id_q, last_id_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [1:0]         win_q, win_d;

  logic [WIDTH-1:0]   words [N_REQ];
  logic [1:0]         cand;
  logic [1:0]         pick;
  logic               found;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      words[i] = d_bus[i*WIDTH +: WIDTH];
    end
  end

  // Search starts just after the last writer so it gets lowest priority next round.
  always_comb begin
    found = 1'b0;
    pick  = 2'd0;
    cand  = 2'd0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = 2'(ptr_q + 2'(k));
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = 4'd0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    q_d       = q_q;
    qbar_d    = qbar_q;
    last_id_d = last_id_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = 4'(1) << pick;
          busy_d  = 1'b1;
          win_d   = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Dropped request is an abort: register and pointer stay as they were.
        if (req[win_q]) begin
          q_d       = words[win_q];
          qbar_d    = ~words[win_q];
          done_d    = 1'b1;
          last_id_d = win_q;
          ptr_d     = win_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (clear) begin
      state_q   <= IDLE;
      gnt_q     <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      q_q       <= '0;
      qbar_q    <= '1;
      last_id_q <= 2'd0;
      ptr_q     <= 2'd3;
      win_q     <= 2'd0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      q_q       <= q_d;
      qbar_q    <= qbar_d;
      last_id_q <= last_id_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign q       = q_q;
  assign qbar    = qbar_q;
  assign last_id = last_id_q;

endmodule

// File: tb/tb_ff_bank_write_arbiter.sv
// Directed bench for ff_bank_write_arbiter; inputs change just after a falling edge,
// outputs are sampled 1 time unit after each falling edge.
module tb_ff_bank_write_arbiter;

  localparam int unsigned WIDTH = 8;

  logic               clk = 1'b0;
  logic               clear;
  logic [3:0]         req;
  logic [4*WIDTH-1:0] d_bus;
  logic [3:0]         gnt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   qbar;
  logic [1:0]         last_id;

  int n_cmp = 0;
  int n_bad = 0;

  ff_bank_write_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .clear(clear), .req(req), .d_bus(d_bus),
    .gnt(gnt), .busy(busy), .done(done), .q(q), .qbar(qbar), .last_id(last_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear = 1'b1; req = 4'b1111; d_bus = {8'h44, 8'h33, 8'h22, 8'h11};
    tick(); tick();
    if (gnt !== 4'b0000) begin n_bad++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b exp=0", busy); end n_cmp++;
    if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got=%b exp=0", done); end n_cmp++;
    if (q !== 8'h00) begin n_bad++; $display("FAIL rst_q got=%h exp=00", q); end n_cmp++;
    if (qbar !== 8'hFF) begin n_bad++; $display("FAIL rst_qbar got=%h exp=ff", qbar); end n_cmp++;
    if (last_id !== 2'd0) begin n_bad++; $display("FAIL rst_last_id got=%0d exp=0", last_id); end n_cmp++;
    clear = 1'b0;
    tick();
    if (gnt !== 4'b0001) begin n_bad++; $display("FAIL rst_first_gnt got=%b exp=0001", gnt); end n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_first_busy got=%b exp=1", busy); end n_cmp++;
    req = 4'b0000;
    tick();
    if (done !== 1'b0 || q !== 8'h00 || gnt !== 4'b0000) begin
      n_bad++; $display("FAIL rst_abort got done=%b q=%h gnt=%b exp done=0 q=00 gnt=0000", done, q, gnt);
    end
    n_cmp++;
  endtask

  // Pointer is still 3 here; requester 2 is the only one asking.
  task automatic test_single();
    req = 4'b0100; d_bus = {8'h00, 8'hA5, 8'h00, 8'h00};
    tick();
    if (gnt !== 4'b0100 || busy !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL single_grant got gnt=%b busy=%b done=%b exp 0100/1/0", gnt, busy, done);
    end
    n_cmp++;
    tick();
    if (q !== 8'hA5) begin n_bad++; $display("FAIL single_q got=%h exp=a5", q); end n_cmp++;
    if (qbar !== 8'h5A) begin n_bad++; $display("FAIL single_qbar got=%h exp=5a", qbar); end n_cmp++;
    if (done !== 1'b1) begin n_bad++; $display("FAIL single_done got=%b exp=1", done); end n_cmp++;
    if (last_id !== 2'd2) begin n_bad++; $display("FAIL single_last_id got=%0d exp=2", last_id); end n_cmp++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_bad++; $display("FAIL single_release got gnt=%b busy=%b exp 0000/0", gnt, busy);
    end
    n_cmp++;
    req = 4'b0000;
    tick();
    if (done !== 1'b0) begin n_bad++; $display("FAIL single_done_pulse got=%b exp=0", done); end n_cmp++;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_q [5];
    logic [3:0] exp_g [5];
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    clear = 1'b1; tick(); clear = 1'b0;
    req = 4'b1111; d_bus = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 5; i++) begin
      tick();
      if (gnt !== exp_g[i] || done !== 1'b0) begin
        n_bad++; $display("FAIL rr_grant%0d got gnt=%b done=%b exp %b/0", i, gnt, done, exp_g[i]);
      end
      n_cmp++;
      tick();
      if (done !== 1'b1 || q !== exp_q[i] || qbar !== ~exp_q[i] || gnt !== 4'b0000) begin
        n_bad++; $display("FAIL rr_write%0d got done=%b q=%h qbar=%h gnt=%b exp 1/%h/%h/0000",
                          i, done, q, qbar, gnt, exp_q[i], ~exp_q[i]);
      end
      n_cmp++;
    end
    req = 4'b0000;
    tick();
  endtask

  // Pointer is 0 after round robin; requester 1 writes, then 3 must beat 0.
  task automatic test_pointer_skip();
    req = 4'b0010;
    tick(); tick();
    if (last_id !== 2'd1 || q !== 8'h22) begin
      n_bad++; $display("FAIL skip_setup got last_id=%0d q=%h exp 1/22", last_id, q);
    end
    n_cmp++;
    req = 4'b1001;
    tick();
    if (gnt !== 4'b1000) begin n_bad++; $display("FAIL skip_gnt3 got=%b exp=1000", gnt); end n_cmp++;
    tick();
    if (last_id !== 2'd3 || q !== 8'h44 || done !== 1'b1) begin
      n_bad++; $display("FAIL skip_write3 got last_id=%0d q=%h done=%b exp 3/44/1", last_id, q, done);
    end
    n_cmp++;
    tick();
    if (gnt !== 4'b0001) begin n_bad++; $display("FAIL skip_gnt0 got=%b exp=0001", gnt); end n_cmp++;
    tick();
    if (last_id !== 2'd0 || q !== 8'h11) begin
      n_bad++; $display("FAIL skip_write0 got last_id=%0d q=%h exp 0/11", last_id, q);
    end
    n_cmp++;
    req = 4'b0000;
    tick();
  endtask

  task automatic test_abort();
    // Abort with pointer 0: pointer must not move to 1.
    req = 4'b0010;
    tick();
    if (gnt !== 4'b0010) begin n_bad++; $display("FAIL abort_gnt got=%b exp=0010", gnt); end n_cmp++;
    req = 4'b0000;
    tick();
    if (done !== 1'b0 || q !== 8'h11 || last_id !== 2'd0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_nowrite got done=%b q=%h last_id=%0d busy=%b exp 0/11/0/0",
                        done, q, last_id, busy);
    end
    n_cmp++;
    req = 4'b0011;
    tick();
    if (gnt !== 4'b0010) begin n_bad++; $display("FAIL abort_ptr0 got=%b exp=0010", gnt); end n_cmp++;
    tick();
    // Requester 3 writes so the pointer becomes 3, then abort requester 1 again.
    req = 4'b1000;
    tick(); tick();
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    if (done !== 1'b0 || q !== 8'h44) begin
      n_bad++; $display("FAIL abort2_nowrite got done=%b q=%h exp 0/44", done, q);
    end
    n_cmp++;
    req = 4'b0011;
    tick();
    if (gnt !== 4'b0001) begin n_bad++; $display("FAIL abort_ptr3 got=%b exp=0001", gnt); end n_cmp++;
    tick();
    if (q !== 8'h11 || last_id !== 2'd0) begin
      n_bad++; $display("FAIL abort_after got q=%h last_id=%0d exp 11/0", q, last_id);
    end
    n_cmp++;
    req = 4'b0000;
    tick();
  endtask

  // Pointer is 0 on entry; after clear, req 0101 must go to 0, not 2.
  task automatic test_clear_mid_grant();
    req = 4'b0100; d_bus = {8'h44, 8'hA5, 8'h22, 8'h11};
    tick();
    if (gnt !== 4'b0100) begin n_bad++; $display("FAIL clr_setup got=%b exp=0100", gnt); end n_cmp++;
    clear = 1'b1;
    tick();
    if (q !== 8'h00 || qbar !== 8'hFF || gnt !== 4'b0000 || done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL clr_mid got q=%h qbar=%h gnt=%b done=%b busy=%b exp 00/ff/0000/0/0",
                        q, qbar, gnt, done, busy);
    end
    n_cmp++;
    clear = 1'b0; req = 4'b0101;
    tick();
    if (gnt !== 4'b0001) begin n_bad++; $display("FAIL clr_restart got=%b exp=0001", gnt); end n_cmp++;
    tick();
    if (q !== 8'h11 || done !== 1'b1) begin
      n_bad++; $display("FAIL clr_write got q=%h done=%b exp 11/1", q, done);
    end
    n_cmp++;
    req = 4'b0000;
    tick();
  endtask

  // Single requester re-granted every 2 cycles; data taken at the GRANT-exit edge.
  task automatic test_back_to_back();
    req = 4'b0100; d_bus = {8'h44, 8'h5C, 8'h22, 8'h11};
    tick();
    if (gnt !== 4'b0100) begin n_bad++; $display("FAIL b2b_gnt1 got=%b exp=0100", gnt); end n_cmp++;
    tick();
    if (q !== 8'h5C || done !== 1'b1) begin
      n_bad++; $display("FAIL b2b_write1 got q=%h done=%b exp 5c/1", q, done);
    end
    n_cmp++;
    tick();
    if (gnt !== 4'b0100 || done !== 1'b0) begin
      n_bad++; $display("FAIL b2b_gnt2 got gnt=%b done=%b exp 0100/0", gnt, done);
    end
    n_cmp++;
    d_bus = {8'h44, 8'h3C, 8'h22, 8'h11};
    tick();
    if (q !== 8'h3C || qbar !== 8'hC3 || done !== 1'b1 || last_id !== 2'd2) begin
      n_bad++; $display("FAIL b2b_write2 got q=%h qbar=%h done=%b last_id=%0d exp 3c/c3/1/2",
                        q, qbar, done, last_id);
    end
    n_cmp++;
    req = 4'b0000;
    tick();
    if (done !== 1'b0 || gnt !== 4'b0000) begin
      n_bad++; $display("FAIL b2b_idle got done=%b gnt=%b exp 0/0000", done, gnt);
    end
    n_cmp++;
  endtask

  initial begin
    clear = 1'b1; req = 4'b0000; d_bus = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_skip();
    test_abort();
    test_clear_mid_grant();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ff_bank_write_arbiter.md
Name: ff_bank_write_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one WIDTH-bit storage register between 4 requesters.
- The register is a bank of falling-edge D flip-flops with complementary outputs.
- Each requester raises req with its data. The block grants one requester, checks that the request is still held, loads the data into the register and pulses done.
- It sits between client logic and a shared status/data register in the gate-level flip-flop library.

Parameters:
- WIDTH, 8, bit width of each data word and of the stored register.

Ports:
- clk, input, 1: clock; all state updates on the falling edge of clk.
- clear, input, 1: synchronous active-high reset, sampled on the falling edge of clk.
- req, input, 4: request per requester; bit i belongs to requester i.
- d_bus, input, 4*WIDTH: concatenated data; requester i drives d_bus[i*WIDTH +: WIDTH].
- gnt, output, 4: one-hot grant, registered.
- busy, output, 1: high while in state GRANT.
- done, output, 1: one-cycle pulse when a write completes.
- q, output, WIDTH: stored register value.
- qbar, output, WIDTH: always the bitwise inverse of q.
- last_id, output, 2: index of the requester whose write most recently completed.

Behaviour:
- Reset (clear=1 at a falling edge) has priority over everything:
  - state=IDLE, gnt=0, busy=0, done=0.
  - q=0, qbar=all ones, last_id=0.
  - Round-robin pointer ptr=3, so requester 0 has first priority.
- Clear asserted mid-GRANT: the pending write is abandoned, q is forced to 0, no done pulse.
- Outputs change only on falling edges of clk. There are no combinational paths from inputs to outputs.
- State IDLE:
  - If req==0: stay in IDLE, gnt=0.
  - Otherwise select winner w. w is the first requester with req[w]=1, searching in order (ptr+1) mod 4, (ptr+2) mod 4, (ptr+3) mod 4, ptr.
  - Next edge: gnt=one-hot(w), busy=1, state=GRANT. The winner index is held internally.
- State GRANT (one cycle), decided at the next edge:
  - If req[w] is still 1: q<=d_bus word w, qbar<=~(that word), done=1 for exactly one cycle, last_id<=w, ptr<=w.
  - If req[w] has dropped (abort): q unchanged, done=0, ptr unchanged.
  - In both cases gnt=0, busy=0, state=IDLE.
- Throughput: at most one write per 2 cycles. Latency from req sampled in IDLE to q updated is 2 falling edges.
- Data is sampled only at the GRANT-exit edge. Changes to d_bus while in IDLE are irrelevant.
- Requests from non-winners that arrive during GRANT are ignored until the next IDLE evaluation. They are not lost, as long as the requester holds req.
- Fairness: with all 4 requesters continuously requesting, grant order is 0,1,2,3,0,...
- A continuously requesting single requester is re-granted every 2 cycles.
- gnt is always 0 or one-hot. busy equals (gnt != 0). done is never asserted in the same cycle as gnt.
- Requesters are expected to hold req until they see done. Dropping req early is treated as an abort, not an error.
- qbar equals ~q at all times, including after reset.

Test Plan:
- Reset: hold clear=1 for 2 cycles with req=4'b1111 → gnt=0, done=0, q=8'h00, qbar=8'hFF, last_id=0. After release, the first grant is gnt=4'b0001.
- Single requester: req=4'b0100, d_bus word2=8'hA5 → edge1 gnt=4'b0100, busy=1; edge2 q=8'hA5, qbar=8'h5A, done=1, last_id=2, gnt=0.
- Round robin: req=4'b1111 held, words 8'h11,8'h22,8'h33,8'h44 → done pulses with q sequence 11,22,33,44,11, one write every 2 cycles.
- Pointer skip: after last_id=1, set req=4'b1001 → grant goes to requester 3 before requester 0. Then keep req=4'b1001 → next grant is requester 0.
- Abort: req=4'b0010, drop req[1] during GRANT → no done, q unchanged, ptr unchanged. A later req=4'b0011 from IDLE grants requester 0 if ptr=3.
- Clear mid-GRANT: assert clear in the GRANT cycle → next edge q=8'h00, gnt=0, done=0, and the next arbitration starts from requester 0.
